// File: rtl/crg_batch_sched.sv
// rtl/crg_batch_sched.sv - batch scheduler for PRNG256 issue, writeback and host readout arbitration
//
// Issues a contiguous run of counter values to PRNG256 (one per cycle). Each
// returning Dvld beat is written to the result RAM at a dense 0-based address.
// The single RAM port is shared with host readout, and writeback always wins.
//
// Optional feature macro: CRG_SCHED_PERF_EN (adds the perf_cycles output).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start                 one-cycle command pulse, accepted only when idle
//   base_cnt, num_blk     first counter value and block count, sampled on start
//   busy, done            batch in flight / one-cycle end-of-batch pulse
//   err_overrun           sticky: excess Dvld or num_blk above 2^ADDR_W
//   err_timeout           sticky: no Dvld for MAX_LAT cycles while draining
//   prng_cnt, prng_drdy   counter value and input-valid to PRNG256
//   prng_dvld             PRNG256 output-valid
//   ram_we, ram_addr      RAM write enable and shared write/read address
//   host_rd_req/addr      host read request (level) and address
//   host_rd_ack           read granted this cycle
//   host_rd_vld           RAM dout valid, one cycle after host_rd_ack
//   perf_cycles           cycles from accepted start through DONE (perf build)

module crg_batch_sched #(
   parameter int CNT_W   = 32,
   parameter int ADDR_W  = 8,
   parameter int MAX_LAT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  base_cnt,
   input  logic [ADDR_W:0]   num_blk,
   output logic              busy,
   output logic              done,
   output logic              err_overrun,
   output logic              err_timeout,
   output logic [CNT_W-1:0]  prng_cnt,
   output logic              prng_drdy,
   input  logic              prng_dvld,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic              host_rd_req,
   input  logic [ADDR_W-1:0] host_rd_addr,
   output logic              host_rd_ack,
   output logic              host_rd_vld
`ifdef CRG_SCHED_PERF_EN
   ,
   output logic [31:0]       perf_cycles
`endif
);

   localparam int WD_W = $clog2(MAX_LAT + 1);
   localparam logic [ADDR_W:0] MAX_BLK = (ADDR_W + 1)'(1) << ADDR_W;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_LAT - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [ADDR_W:0]   num_q;
   logic [ADDR_W:0]   issued_q;
   logic [ADDR_W:0]   returned_q;
   logic [ADDR_W:0]   returned_d;
   logic [WD_W-1:0]   wd_q;
   logic              busy_q;
   logic              done_q;
   logic              ovr_q;
   logic              tmo_q;
   logic              drdy_q;
   logic              rd_vld_q;
   logic              active;
   logic              beat_wr;
   logic              beat_ovr;
`ifdef CRG_SCHED_PERF_EN
   logic [31:0]       perf_q;
`endif

   // Dvld only counts while a batch is in flight; a beat past num_blk is
   // flagged but never written.
   assign active   = (state_q == ISSUE) || (state_q == DRAIN);
   assign beat_wr  = active && prng_dvld && (returned_q < num_q);
   assign beat_ovr = active && prng_dvld && !(returned_q < num_q);

   assign returned_d = returned_q + {{ADDR_W{1'b0}}, beat_wr};

   // Writeback owns the RAM port whenever it writes; the host waits otherwise.
   assign ram_we      = beat_wr;
   assign ram_addr    = beat_wr ? returned_q[ADDR_W-1:0] : host_rd_addr;
   assign host_rd_ack = host_rd_req && !beat_wr;

   assign busy        = busy_q;
   assign done        = done_q;
   assign err_overrun = ovr_q;
   assign err_timeout = tmo_q;
   assign prng_cnt    = cnt_q;
   assign prng_drdy   = drdy_q;
   assign host_rd_vld = rd_vld_q;
`ifdef CRG_SCHED_PERF_EN
   assign perf_cycles = perf_q;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         num_q      <= '0;
         issued_q   <= '0;
         returned_q <= '0;
         wd_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         ovr_q      <= 1'b0;
         tmo_q      <= 1'b0;
         drdy_q     <= 1'b0;
         rd_vld_q   <= 1'b0;
`ifdef CRG_SCHED_PERF_EN
         perf_q     <= '0;
`endif
      end else begin
         done_q     <= 1'b0;
         rd_vld_q   <= host_rd_ack;
         returned_q <= returned_d;
         if (beat_ovr) begin
            ovr_q <= 1'b1;
         end
`ifdef CRG_SCHED_PERF_EN
         if (state_q != IDLE) begin
            perf_q <= perf_q + 32'd1;
         end
`endif
         case (state_q)
            IDLE: begin
               if (start) begin
                  tmo_q      <= 1'b0;
                  returned_q <= '0;
                  issued_q   <= '0;
                  wd_q       <= '0;
                  num_q      <= num_blk;
`ifdef CRG_SCHED_PERF_EN
                  perf_q     <= 32'd1;
`endif
                  if (num_blk == '0) begin
                     ovr_q   <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else if (num_blk > MAX_BLK) begin
                     ovr_q   <= 1'b1;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     // First issue is presented in the very next cycle, so
                     // it is already counted here.
                     ovr_q    <= 1'b0;
                     cnt_q    <= base_cnt;
                     drdy_q   <= 1'b1;
                     busy_q   <= 1'b1;
                     issued_q <= (ADDR_W + 1)'(1);
                     state_q  <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               wd_q <= '0;
               if (issued_q == num_q) begin
                  drdy_q  <= 1'b0;
                  state_q <= DRAIN;
               end else begin
                  cnt_q    <= cnt_q + CNT_W'(1);
                  issued_q <= issued_q + (ADDR_W + 1)'(1);
               end
            end
            DRAIN: begin
               // Completion is judged on the registered count, so a surplus
               // beat right after the last one is still seen as an overrun.
               if (returned_q == num_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (prng_dvld) begin
                  wd_q <= '0;
               end else if (wd_q == WD_LAST) begin
                  tmo_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  wd_q <= wd_q + WD_W'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crg_batch_sched.sv
// tb/tb_crg_batch_sched.sv - self-checking bench for crg_batch_sched
module tb_crg_batch_sched;

   localparam int MAX_LAT = 16;
   localparam int NMAX    = 256;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [31:0] base_cnt = '0;
   logic [8:0]  num_blk = '0;
   logic        busy, done, err_overrun, err_timeout;
   logic [31:0] prng_cnt;
   logic        prng_drdy;
   logic        prng_dvld = 1'b0;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic        host_rd_req = 1'b0;
   logic [7:0]  host_rd_addr = '0;
   logic        host_rd_ack, host_rd_vld;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit prev_ack = 1'b0;

   crg_batch_sched dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .base_cnt     (base_cnt),
      .num_blk      (num_blk),
      .busy         (busy),
      .done         (done),
      .err_overrun  (err_overrun),
      .err_timeout  (err_timeout),
      .prng_cnt     (prng_cnt),
      .prng_drdy    (prng_drdy),
      .prng_dvld    (prng_dvld),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .host_rd_req  (host_rd_req),
      .host_rd_addr (host_rd_addr),
      .host_rd_ack  (host_rd_ack),
      .host_rd_vld  (host_rd_vld)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // One batch. Beat j of the PRNG model returns lat cycles after issue j.
   // extra: surplus beats after the last; drop: trailing beats withheld;
   // hmode: 0 no host, 1 hold request at haddr, 2 random requests.
   task automatic run_batch(input logic [31:0] base, input int n, input int lat,
                            input int extra, input int drop, input int hmode,
                            input logic [7:0] haddr, input bit start_mid);
      int T, D, L, S, nb, beats, ovc, c, j;
      bit legal, dv, exp_we, exp_ack, issuing;
      logic [31:0] exp_cnt;

      tick();
      T = cyc;
      start = 1'b1;
      base_cnt = base;
      num_blk = 9'(n);
      prng_dvld = 1'b0;
      host_rd_req = (hmode != 0);
      host_rd_addr = haddr;
      #2;
      chk("we_at_start", ram_we, 0);
      chk("ack_at_start", host_rd_ack, host_rd_req);
      chk("rdvld_at_start", host_rd_vld, prev_ack);
      prev_ack = host_rd_req;

      legal = (n >= 1) && (n <= NMAX);
      beats = legal ? (n + extra - drop) : 0;
      ovc = 1 << 30;
      if (!legal) begin
         D = T + 1;
         if (n > NMAX) ovc = T + 1;
      end else if (drop == 0) begin
         L = T + lat + n;
         D = ((L > T + n) ? L : T + n) + 2;
         if (extra > 0) ovc = T + lat + n + 2;
      end else begin
         nb = n - drop;
         L = (nb > 0) ? T + lat + nb : T;
         S = (L + 1 > T + n + 1) ? L + 1 : T + n + 1;
         D = S + MAX_LAT;
      end

      for (int k = 1; k <= D - T + 2; k++) begin
         tick();
         c = cyc;
         start = start_mid && (k == 3);
         if (start) begin
            base_cnt = $urandom;
            num_blk = 9'($urandom_range(1, 20));
         end
         j = c - (T + 1 + lat);
         dv = legal && (j >= 0) && (j < beats);
         prng_dvld = dv;
         if (hmode == 2) begin
            host_rd_req = $urandom_range(0, 1) != 0;
            host_rd_addr = 8'($urandom);
         end
         #2;
         issuing = legal && (c >= T + 1) && (c <= T + n);
         chk("drdy", prng_drdy, issuing);
         if (issuing) begin
            exp_cnt = base + 32'(c - T - 1);
            chk("prng_cnt", prng_cnt, exp_cnt);
         end
         exp_we = dv && (j < n) && (c < D);
         chk("ram_we", ram_we, exp_we);
         if (exp_we) chk("wr_addr", ram_addr, 32'(j));
         exp_ack = host_rd_req && !exp_we;
         chk("rd_ack", host_rd_ack, exp_ack);
         if (exp_ack) chk("rd_addr", ram_addr, host_rd_addr);
         chk("rd_vld", host_rd_vld, prev_ack);
         prev_ack = exp_ack;
         chk("busy", busy, legal && (c >= T + 1) && (c < D));
         chk("done", done, c == D);
         chk("err_overrun", err_overrun, c >= ovc);
         chk("err_timeout", err_timeout, legal && (drop > 0) && (c >= D));
      end
      start = 1'b0;
      prng_dvld = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   initial begin
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ovr", err_overrun, 0);
      chk("rst_tmo", err_timeout, 0);
      chk("rst_drdy", prng_drdy, 0);
      chk("rst_cnt", prng_cnt, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_rdvld", host_rd_vld, 0);
      rst_n = 1'b1;
      tick();

      run_batch(32'h100, 4, 10, 0, 0, 0, 8'h00, 1'b0);
      run_batch(32'hFFFF_FFFE, 256, 10, 0, 0, 1, 8'h02, 1'b0);
      run_batch(32'h2000, 4, 10, 1, 0, 1, 8'h07, 1'b0);
      run_batch(32'h3000, 4, 10, 0, 1, 2, 8'h00, 1'b1);
      run_batch(32'h4000, 0, 10, 0, 0, 0, 8'h00, 1'b0);
      run_batch(32'h5000, 300, 10, 0, 0, 2, 8'h00, 1'b0);

      // Asynchronous reset in the middle of ISSUE.
      host_rd_req = 1'b0;
      tick();
      start = 1'b1;
      base_cnt = 32'h55;
      num_blk = 9'd8;
      tick();
      start = 1'b0;
      tick();
      #2;
      chk("pre_rst_drdy", prng_drdy, 1);
      rst_n = 1'b0;
      prng_dvld = 1'b1;
      #1;
      chk("async_drdy", prng_drdy, 0);
      chk("async_busy", busy, 0);
      chk("async_we", ram_we, 0);
      chk("async_cnt", prng_cnt, 0);
      tick();
      rst_n = 1'b1;
      prng_dvld = 1'b0;
      prev_ack = 1'b0;
      #2;
      chk("post_rst_drdy", prng_drdy, 0);
      chk("post_rst_rdvld", host_rd_vld, 0);

      for (int r = 0; r < 10; r++) begin
         int rn, rl, rx, rd;
         rn = $urandom_range(1, 40);
         rl = $urandom_range(0, 12);
         rx = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         rd = (rx == 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
         if (rd > rn) rd = rn;
         run_batch($urandom, rn, rl, rx, rd, 2, 8'h00, ($urandom_range(0, 1) != 0) && rn >= 3);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
